contador_rx_monitor: RTL and testbench

- Receive-side checker for the 4-bit contador output interface (Q, rco, load).
- Observes the same command inputs that drive the counter (enable, mode, D) plus its outputs.
- Runs a registered reference model of the counter and flags any mismatch in Q, rco or load.
- Counts ripple-carry events and errors.
- Sits beside a counter instance, or at the far end of a cascade, to qualify its output stream.

---
 rtl/contador_rx_monitor.sv | 169 ++++++++++++++++
 tb/tb_contador_rx_monitor.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/contador_rx_monitor.sv
// contador_rx_monitor: receive-side checker for a WIDTH-bit contador.
// Tracks the counter with a one-cycle registered reference model.
// It flags Q/rco/load mismatches as one-cycle pulses, keeps a saturating
// count of error cycles and counts rco wrap events.
// Optional build macro: CONTADOR_MON_HALT_EN. When it is defined, the first
// mismatch in SYNC freezes the monitor in HALT until clr or reset.
module contador_rx_monitor #(
  parameter int WIDTH = 4,
  parameter int ERR_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] D,
  input  logic [WIDTH-1:0] Q,
  input  logic             rco,
  input  logic             load,
  input  logic             clr,
  output logic             synced,
  output logic             err_q,
  output logic             err_rco,
  output logic             err_load,
  output logic [ERR_W-1:0] err_count,
  output logic [ERR_W-1:0] wrap_count
);

`ifdef CONTADOR_MON_HALT_EN
  typedef enum logic [1:0] {ST_UNSYNC = 2'd0, ST_SYNC = 2'd1, ST_HALT = 2'd2} state_t;
`else
  typedef enum logic [1:0] {ST_UNSYNC = 2'd0, ST_SYNC = 2'd1} state_t;
`endif

  localparam logic [WIDTH:0]   STEP_ONE   = (WIDTH+1)'(1);
  localparam logic [WIDTH:0]   STEP_THREE = (WIDTH+1)'(3);
  localparam logic [ERR_W-1:0] CNT_MAX    = {ERR_W{1'b1}};

  state_t           state_q, state_d;
  logic             prev_en_q;
  logic [1:0]       prev_mode_q;
  logic [WIDTH-1:0] prev_d_q;
  logic [WIDTH-1:0] prev_qv_q;
  logic             err_q_q, err_q_d;
  logic             err_rco_q, err_rco_d;
  logic             err_load_q, err_load_d;
  logic [ERR_W-1:0] err_count_q, err_count_d;
  logic [ERR_W-1:0] wrap_count_q, wrap_count_d;

  logic [WIDTH:0]   exp_sum;
  logic [WIDTH-1:0] exp_q;
  logic             exp_rco;
  logic             exp_load;
  logic             mis_q, mis_rco, mis_load, mis_any;

  // Capture last cycle's command and observed Q; the model always follows observed Q.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev_en_q   <= 1'b0;
      prev_mode_q <= 2'b00;
      prev_d_q    <= '0;
      prev_qv_q   <= '0;
    end else begin
      prev_en_q   <= enable;
      prev_mode_q <= mode;
      prev_d_q    <= D;
      prev_qv_q   <= Q;
    end
  end

  // Reference step: expected Q/rco/load for this cycle from the captured previous cycle.
  always_comb begin
    exp_sum  = {1'b0, prev_qv_q};
    exp_q    = prev_qv_q;
    exp_rco  = 1'b0;
    exp_load = 1'b0;
    if (prev_en_q) begin
      case (prev_mode_q)
        2'b00: begin
          exp_sum = {1'b0, prev_qv_q} + STEP_ONE;
          exp_q   = exp_sum[WIDTH-1:0];
          exp_rco = exp_sum[WIDTH];
        end
        2'b01: begin
          // Borrow out of the top bit marks a down step from zero.
          exp_sum = {1'b0, prev_qv_q} - STEP_ONE;
          exp_q   = exp_sum[WIDTH-1:0];
          exp_rco = exp_sum[WIDTH];
        end
        2'b10: begin
          exp_sum = {1'b0, prev_qv_q} + STEP_THREE;
          exp_q   = exp_sum[WIDTH-1:0];
          exp_rco = exp_sum[WIDTH];
        end
        default: begin
          exp_q    = prev_d_q;
          exp_load = 1'b1;
        end
      endcase
    end
    mis_q    = (Q != exp_q);
    mis_rco  = (rco != exp_rco);
    mis_load = (load != exp_load);
    mis_any  = mis_q | mis_rco | mis_load;
  end

  // Next-state and next-output logic; clr overrides everything else.
  always_comb begin
    state_d      = state_q;
    err_q_d      = 1'b0;
    err_rco_d    = 1'b0;
    err_load_d   = 1'b0;
    err_count_d  = err_count_q;
    wrap_count_d = wrap_count_q;
    if (clr) begin
      state_d      = ST_UNSYNC;
      err_count_d  = '0;
      wrap_count_d = '0;
    end else begin
      case (state_q)
        ST_UNSYNC: begin
          if (load) state_d = ST_SYNC;
        end
        ST_SYNC: begin
          err_q_d    = mis_q;
          err_rco_d  = mis_rco;
          err_load_d = mis_load;
          if (mis_any && (err_count_q != CNT_MAX)) err_count_d = err_count_q + 1'b1;
          if (rco) wrap_count_d = wrap_count_q + 1'b1;
`ifdef CONTADOR_MON_HALT_EN
          if (mis_any) state_d = ST_HALT;
`endif
        end
`ifdef CONTADOR_MON_HALT_EN
        ST_HALT: begin
          state_d = ST_HALT;
        end
`endif
        default: state_d = ST_UNSYNC;
      endcase
    end
  end

  // State, error pulse and counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_UNSYNC;
      err_q_q      <= 1'b0;
      err_rco_q    <= 1'b0;
      err_load_q   <= 1'b0;
      err_count_q  <= '0;
      wrap_count_q <= '0;
    end else begin
      state_q      <= state_d;
      err_q_q      <= err_q_d;
      err_rco_q    <= err_rco_d;
      err_load_q   <= err_load_d;
      err_count_q  <= err_count_d;
      wrap_count_q <= wrap_count_d;
    end
  end

  assign synced     = (state_q != ST_UNSYNC);
  assign err_q      = err_q_q;
  assign err_rco    = err_rco_q;
  assign err_load   = err_load_q;
  assign err_count  = err_count_q;
  assign wrap_count = wrap_count_q;

endmodule

// File: tb/tb_contador_rx_monitor.sv
// Bench for contador_rx_monitor. It runs a directed vector table, a
// saturation/wrap sequence, a random counter stream with injected faults
// checked against a behavioural model, and an asynchronous reset sequence.
module tb_contador_rx_monitor;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       enable = 1'b0;
  logic [1:0] mode = 2'b00;
  logic [3:0] D = 4'h0;
  logic [3:0] Q = 4'h0;
  logic       rco = 1'b0;
  logic       load = 1'b0;
  logic       clr = 1'b0;
  logic       synced, err_q, err_rco, err_load;
  logic [7:0] err_count, wrap_count;

  int checks = 0;
  int failures = 0;

  contador_rx_monitor #(.WIDTH(4), .ERR_W(8)) dut (
    .clk(clk), .reset(reset), .enable(enable), .mode(mode), .D(D), .Q(Q),
    .rco(rco), .load(load), .clr(clr), .synced(synced), .err_q(err_q),
    .err_rco(err_rco), .err_load(err_load), .err_count(err_count),
    .wrap_count(wrap_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       en;
    logic [1:0] md;
    logic [3:0] d;
    logic [3:0] q;
    logic       rc;
    logic       ld;
    logic       cl;
    logic       s;
    logic       eq;
    logic       er;
    logic       el;
    logic [7:0] ec;
    logic [7:0] wc;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic s, input logic eq, input logic er,
                         input logic el, input logic [7:0] ec, input logic [7:0] wc);
    chk({tag, " synced"}, synced, s);
    chk({tag, " err_q"}, err_q, eq);
    chk({tag, " err_rco"}, err_rco, er);
    chk({tag, " err_load"}, err_load, el);
    chk({tag, " err_count"}, err_count, ec);
    chk({tag, " wrap_count"}, wrap_count, wc);
  endtask

  task automatic drive(input logic en, input logic [1:0] md, input logic [3:0] d,
                       input logic [3:0] q, input logic rc, input logic ld, input logic cl);
    enable = en; mode = md; D = d; Q = q; rco = rc; load = ld; clr = cl;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Behavioural expectation of a correct counter step, in plain integer arithmetic.
  task automatic expect_step(input int en, input int md, input int d, input int q,
                             output int nq, output int nrco, output int nld);
    int s;
    nq = q; nrco = 0; nld = 0;
    if (en != 0) begin
      if (md == 3) begin
        nq = d; nld = 1;
      end else if (md == 1) begin
        nq = (q + 15) % 16; nrco = (q == 0) ? 1 : 0;
      end else begin
        s = q + ((md == 2) ? 3 : 1);
        nq = s % 16; nrco = (s > 15) ? 1 : 0;
      end
    end
  endtask

  vec_t vecs[20];

  initial begin
    int pen, pmd, pd, pq, cq, crco, cld, nq, nrco, nld, eq_v, er_v, el_v, r;
    int mec, mwc;
    bit ms, mh, xq, xr, xl, c, en;
    int md, d;

    // Reset state
    drive(0, 0, 0, 0, 0, 0, 0);
    reset = 1'b0;
    tick();
    chk_all("reset", 0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    tick();
    chk_all("post_release", 0, 0, 0, 0, 0, 0);

`ifndef CONTADOR_MON_HALT_EN
    //            en md  d     q     rc ld cl   s eq er el ec wc
    vecs[0]  = '{1, 3, 4'hE, 4'h0, 0, 0, 0,   0, 0, 0, 0, 0, 0};
    vecs[1]  = '{1, 0, 4'h0, 4'hE, 0, 1, 0,   1, 0, 0, 0, 0, 0};
    vecs[2]  = '{1, 0, 4'h0, 4'hF, 0, 0, 0,   1, 0, 0, 0, 0, 0};
    vecs[3]  = '{1, 0, 4'h0, 4'h0, 1, 0, 0,   1, 0, 0, 0, 0, 1};
    vecs[4]  = '{1, 3, 4'hD, 4'h1, 0, 0, 0,   1, 0, 0, 0, 0, 1};
    vecs[5]  = '{1, 2, 4'h0, 4'hD, 0, 1, 0,   1, 0, 0, 0, 0, 1};
    vecs[6]  = '{1, 1, 4'h0, 4'h1, 1, 0, 0,   1, 1, 0, 0, 1, 2};
    vecs[7]  = '{1, 1, 4'h0, 4'h0, 0, 0, 0,   1, 0, 0, 0, 1, 2};
    vecs[8]  = '{1, 0, 4'h0, 4'hF, 0, 0, 0,   1, 0, 1, 0, 2, 2};
    vecs[9]  = '{1, 0, 4'h0, 4'h0, 1, 0, 0,   1, 0, 0, 0, 2, 3};
    vecs[10] = '{1, 0, 4'h0, 4'h5, 0, 0, 1,   0, 0, 0, 0, 0, 0};
    vecs[11] = '{0, 0, 4'h0, 4'h9, 0, 0, 0,   0, 0, 0, 0, 0, 0};
    vecs[12] = '{0, 0, 4'h0, 4'h3, 1, 0, 0,   0, 0, 0, 0, 0, 0};
    vecs[13] = '{0, 0, 4'h0, 4'h7, 0, 1, 0,   1, 0, 0, 0, 0, 0};
    vecs[14] = '{0, 0, 4'h0, 4'h7, 0, 0, 0,   1, 0, 0, 0, 0, 0};
    vecs[15] = '{0, 0, 4'h0, 4'h7, 0, 1, 0,   1, 0, 0, 1, 1, 0};
    vecs[16] = '{1, 3, 4'h2, 4'h7, 0, 1, 1,   0, 0, 0, 0, 0, 0};
    vecs[17] = '{1, 0, 4'h0, 4'h2, 0, 1, 0,   1, 0, 0, 0, 0, 0};
    vecs[18] = '{1, 0, 4'h0, 4'h3, 0, 0, 0,   1, 0, 0, 0, 0, 0};
    vecs[19] = '{1, 0, 4'h0, 4'h9, 1, 1, 0,   1, 1, 1, 1, 1, 1};
    for (int i = 0; i < 20; i++) begin
      drive(vecs[i].en, vecs[i].md, vecs[i].d, vecs[i].q, vecs[i].rc, vecs[i].ld, vecs[i].cl);
      tick();
      chk_all($sformatf("vec%0d", i), vecs[i].s, vecs[i].eq, vecs[i].er, vecs[i].el,
              vecs[i].ec, vecs[i].wc);
      $display("vec %0d q=%h rco=%0d load=%0d clr=%0d -> synced=%0d err=%0d%0d%0d cnt=%0d wrap=%0d",
               i, vecs[i].q, vecs[i].rc, vecs[i].ld, vecs[i].cl, synced, err_q, err_rco,
               err_load, err_count, wrap_count);
    end

    // Saturation of err_count and modulo wrap of wrap_count.
    drive(0, 0, 0, 0, 0, 0, 1); tick();
    drive(0, 0, 0, 0, 0, 1, 0); tick();
    chk("sat lock synced", synced, 1);
    for (int i = 0; i < 260; i++) begin
      drive(0, 0, 0, (i % 2 == 0) ? 4'h1 : 4'h0, 1, 0, 0);
      tick();
      if (i == 254) chk("sat err_count at 255", err_count, 255);
      if (i == 255) chk("wrap_count rolls to 0", wrap_count, 0);
    end
    chk_all("sat end", 1, 1, 1, 0, 255, 4);
    $display("saturation run: err_count=%0d wrap_count=%0d", err_count, wrap_count);
`else
    // HALT: two consecutive mismatches give one pulse and one count.
    drive(0, 0, 0, 0, 0, 0, 1); tick();
    drive(0, 0, 0, 0, 0, 1, 0); tick();
    chk_all("halt lock", 1, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 4'h1, 0, 0, 0); tick();
    chk_all("halt first", 1, 1, 0, 0, 1, 0);
    drive(0, 0, 0, 4'h2, 1, 0, 0); tick();
    chk_all("halt second", 1, 0, 0, 0, 1, 0);
    drive(0, 0, 0, 4'h2, 0, 0, 1); tick();
    chk_all("halt clr", 0, 0, 0, 0, 0, 0);
    $display("halt sequence done: synced=%0d err_count=%0d", synced, err_count);
`endif

    // Random counter stream with injected faults against the behavioural model.
    drive(0, 0, 0, 0, 0, 0, 0);
    reset = 1'b0; tick(); reset = 1'b1;
    pen = 0; pmd = 0; pd = 0; pq = 0;
    cq = 0; crco = 0; cld = 0;
    ms = 0; mh = 0; mec = 0; mwc = 0;
    for (int i = 0; i < 400; i++) begin
      en = ($urandom_range(0, 7) != 0);
      md = $urandom_range(0, 3);
      d  = $urandom_range(0, 15);
      c  = ($urandom_range(0, 39) == 0);
      drive(en, md[1:0], d[3:0], cq[3:0], crco[0], cld[0], c);
      expect_step(pen, pmd, pd, pq, eq_v, er_v, el_v);
      xq = 0; xr = 0; xl = 0;
      if (c) begin
        ms = 0; mh = 0; mec = 0; mwc = 0;
      end else if (!ms) begin
        if (cld != 0) ms = 1;
      end else if (!mh) begin
        xq = (cq != eq_v); xr = (crco != er_v); xl = (cld != el_v);
        if (xq || xr || xl) begin
          if (mec < 255) mec++;
`ifdef CONTADOR_MON_HALT_EN
          mh = 1;
`endif
        end
        if (crco != 0) mwc = (mwc + 1) % 256;
      end
      expect_step(en, md, d, cq, nq, nrco, nld);
      r = $urandom_range(0, 29);
      if (r == 0) nq = nq ^ $urandom_range(1, 15);
      if (r == 1) nrco = 1 - nrco;
      if (r == 2) nld = 1 - nld;
      pen = en; pmd = md; pd = d; pq = cq;
      tick();
      chk_all($sformatf("rand%0d", i), ms, xq, xr, xl, mec[7:0], mwc[7:0]);
      $display("rand %0d en=%0d mode=%0d q=%h rco=%0d load=%0d clr=%0d -> synced=%0d err=%0d%0d%0d cnt=%0d wrap=%0d",
               i, en, md, cq, crco, cld, c, synced, err_q, err_rco, err_load, err_count, wrap_count);
      cq = nq; crco = nrco; cld = nld;
    end

    // Asynchronous reset in mid-cycle, then no checking until a fresh load.
    drive(0, 0, 0, 0, 0, 1, 0); tick();
    drive(0, 0, 0, 4'h6, 1, 0, 0);
    #2 reset = 1'b0;
    #1 chk_all("async reset", 0, 0, 0, 0, 0, 0);
    tick();
    reset = 1'b1;
    drive(1, 0, 0, 4'h9, 1, 0, 0); tick();
    drive(1, 0, 0, 4'h2, 0, 0, 0); tick();
    chk_all("after reset no load", 0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 4'h2, 0, 1, 0); tick();
    chk_all("after reset load", 1, 0, 0, 0, 0, 0);
    $display("reset sequence done: synced=%0d", synced);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
